// File: rtl/alarm_seq_pkg.sv
// Shared types and constants for the alarm ringer sequencer.
package alarm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  localparam int unsigned DEF_CLK_FREQ       = 32'd50000000;
  localparam int unsigned DEF_BURST_SECONDS  = 32'd5;
  localparam int unsigned DEF_SNOOZE_SECONDS = 32'd300;
  localparam int unsigned DEF_RING_TIMEOUT   = 32'd60;
  localparam int unsigned DEF_MAX_SNOOZES    = 32'd3;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int unsigned sec_cnt_w(input int unsigned max_val);
    return (max_val > 32'd0) ? $clog2(max_val + 32'd1) : 32'd1;
  endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Control/status bundle between alarm-compare logic, the sequencer and the ringer.
interface alarm_sequencer_if #(
  parameter int unsigned CNT_W = 2
);
  logic             armed;
  logic             alarm_match;
  logic             snooze_btn;
  logic             dismiss_btn;
  logic             ring_on;
  logic             ringing;
  logic             snoozing;
  logic [CNT_W-1:0] snooze_cnt;

  modport master (
    output armed, alarm_match, snooze_btn, dismiss_btn,
    input  ring_on, ringing, snoozing, snooze_cnt
  );

  modport slave (
    input  armed, alarm_match, snooze_btn, dismiss_btn,
    output ring_on, ringing, snoozing, snooze_cnt
  );
endinterface

// File: rtl/alarm_sequencer_sec_tick_gen.sv
// One-second tick prescaler; clear restarts the count so the next tick is a full second away.
module sec_tick_gen #(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int unsigned PW = (CLK_FREQ > 32'd1) ? $clog2(CLK_FREQ) : 32'd1;
  localparam logic [PW-1:0] LAST = PW'(CLK_FREQ - 32'd1);

  logic [PW-1:0] presc_q;

  // Free-running prescaler with wrap and external restart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (clear || (presc_q == LAST)) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Not gated by clear: the FSM's clear depends on tick, and entry overrides counting anyway.
  assign tick = (presc_q == LAST);
endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ringer sequencer: IDLE/RING/SNOOZE control with bursts, snooze limit and ring timeout.
// Optional ALARM_SEQ_AUTO_SNOOZE_EN: an unattended ring timeout counts as a snooze.
module alarm_sequencer
  import alarm_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = DEF_CLK_FREQ,
  parameter int unsigned BURST_SECONDS  = DEF_BURST_SECONDS,
  parameter int unsigned SNOOZE_SECONDS = DEF_SNOOZE_SECONDS,
  parameter int unsigned RING_TIMEOUT   = DEF_RING_TIMEOUT,
  parameter int unsigned MAX_SNOOZES    = DEF_MAX_SNOOZES
) (
  input logic              clk,
  input logic              rst_n,
  alarm_sequencer_if.slave bus
);
  localparam int unsigned CNT_W = sec_cnt_w(MAX_SNOOZES);
  localparam int unsigned RS_W  = sec_cnt_w(RING_TIMEOUT);
  localparam int unsigned BS_W  = sec_cnt_w(BURST_SECONDS);
  localparam int unsigned WS_W  = sec_cnt_w(SNOOZE_SECONDS);
  localparam logic [CNT_W-1:0] SNZ_MAX = CNT_W'(MAX_SNOOZES);
  localparam logic [RS_W-1:0]  RS_END  = RS_W'(RING_TIMEOUT);
  localparam logic [BS_W-1:0]  BS_END  = BS_W'(BURST_SECONDS);
  localparam logic [WS_W-1:0]  WS_END  = WS_W'(SNOOZE_SECONDS);

  alarm_state_t     state_q, state_d;
  logic [CNT_W-1:0] snooze_cnt_q, snooze_cnt_d;
  logic [RS_W-1:0]  ring_sec_q, ring_sec_d, ring_sec_inc_s;
  logic [BS_W-1:0]  burst_sec_q, burst_sec_d, burst_sec_inc_s;
  logic [WS_W-1:0]  wait_sec_q, wait_sec_d, wait_sec_inc_s;
  logic             ring_on_q, ring_on_d;
  logic             ringing_q, snoozing_q;
  logic             snooze_prev_q, dismiss_prev_q;
  logic             snooze_ev_s, dismiss_ev_s, tick_s, enter_s;

  sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (enter_s),
    .tick  (tick_s)
  );

  assign snooze_ev_s     = bus.snooze_btn & ~snooze_prev_q;
  assign dismiss_ev_s    = bus.dismiss_btn & ~dismiss_prev_q;
  assign ring_sec_inc_s  = ring_sec_q + RS_W'(1);
  assign burst_sec_inc_s = burst_sec_q + BS_W'(1);
  assign wait_sec_inc_s  = wait_sec_q + WS_W'(1);

  // Next-state decision; priority is !armed > dismiss > snooze > timeout/expiry.
  always_comb begin
    state_d      = state_q;
    snooze_cnt_d = snooze_cnt_q;
    ring_sec_d   = ring_sec_q;
    burst_sec_d  = burst_sec_q;
    wait_sec_d   = wait_sec_q;
    ring_on_d    = 1'b0;
    enter_s      = 1'b0;
    if (!bus.armed) begin
      state_d = IDLE;
      enter_s = (state_q != IDLE);
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.alarm_match) begin
            state_d      = RING;
            snooze_cnt_d = '0;
            ring_on_d    = 1'b1;
            enter_s      = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        RING: begin
          if (dismiss_ev_s) begin
            state_d = IDLE;
            enter_s = 1'b1;
          end else if (snooze_ev_s) begin
            enter_s = 1'b1;
            if (snooze_cnt_q == SNZ_MAX) begin
              state_d = IDLE;
            end else begin
              state_d      = SNOOZE;
              snooze_cnt_d = snooze_cnt_q + CNT_W'(1);
            end
          end else if (tick_s && (ring_sec_inc_s == RS_END)) begin
            enter_s = 1'b1;
`ifdef ALARM_SEQ_AUTO_SNOOZE_EN
            if (snooze_cnt_q == SNZ_MAX) begin
              state_d = IDLE;
            end else begin
              state_d      = SNOOZE;
              snooze_cnt_d = snooze_cnt_q + CNT_W'(1);
            end
`else
            state_d = IDLE;
`endif
          end else if (tick_s) begin
            ring_sec_d = ring_sec_inc_s;
            if (burst_sec_inc_s == BS_END) begin
              burst_sec_d = '0;
              ring_on_d   = 1'b1;
            end else begin
              burst_sec_d = burst_sec_inc_s;
            end
          end else begin
            state_d = RING;
          end
        end
        SNOOZE: begin
          if (dismiss_ev_s) begin
            state_d = IDLE;
            enter_s = 1'b1;
          end else if (tick_s && (wait_sec_inc_s == WS_END)) begin
            state_d   = RING;
            ring_on_d = 1'b1;
            enter_s   = 1'b1;
          end else if (tick_s) begin
            wait_sec_d = wait_sec_inc_s;
          end else begin
            state_d = SNOOZE;
          end
        end
        default: begin
          state_d = IDLE;
          enter_s = 1'b1;
        end
      endcase
    end
    if (enter_s) begin
      ring_sec_d  = '0;
      burst_sec_d = '0;
      wait_sec_d  = '0;
    end else begin
      ring_sec_d = ring_sec_d;
    end
  end

  // State, counters, edge history and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      snooze_cnt_q   <= '0;
      ring_sec_q     <= '0;
      burst_sec_q    <= '0;
      wait_sec_q     <= '0;
      ring_on_q      <= 1'b0;
      ringing_q      <= 1'b0;
      snoozing_q     <= 1'b0;
      snooze_prev_q  <= 1'b0;
      dismiss_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      snooze_cnt_q   <= snooze_cnt_d;
      ring_sec_q     <= ring_sec_d;
      burst_sec_q    <= burst_sec_d;
      wait_sec_q     <= wait_sec_d;
      ring_on_q      <= ring_on_d;
      ringing_q      <= (state_d == RING);
      snoozing_q     <= (state_d == SNOOZE);
      snooze_prev_q  <= bus.snooze_btn;
      dismiss_prev_q <= bus.dismiss_btn;
    end
  end

  assign bus.ring_on    = ring_on_q;
  assign bus.ringing    = ringing_q;
  assign bus.snoozing   = snoozing_q;
  assign bus.snooze_cnt = snooze_cnt_q;
endmodule
